hex_display_mux: RTL

Time-multiplexed driver for a 4-digit common-anode 7-segment display. Consumes the 16-bit count from the free-running 16-bit counter and shows it as four hexadecimal digits. Scans one digit at a time with a programmable slot length and an anti-ghosting dead time, and snapshots the input once per frame so a frame never mixes two different counts. Sits directly downstream of the counter and drives the board's anode and segment pins.

---
 rtl/hex_display_mux.sv | 103 ++++++++++
 1 files changed

// File: rtl/hex_display_mux.sv
// hex_display_mux: 4-digit common-anode 7-segment scanner with per-frame value snapshot and dead time.
// Define HEX_LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 is always shown).
module hex_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] TICK_LIT  = TW'(BLANK_CYC);

  logic [TW-1:0] tick_cnt;
  logic [1:0]    digit;
  logic [15:0]   snap;
  logic [3:0]    nibble;
  logic          lead_zero;
  logic          active;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign nibble = snap[{digit, 2'b00} +: 4];

`ifdef HEX_LEADING_ZERO_BLANK_EN
  always_comb begin
    case (digit)
      2'd3:    lead_zero = (snap[15:12] == '0);
      2'd2:    lead_zero = (snap[15:8]  == '0);
      2'd1:    lead_zero = (snap[15:4]  == '0);
      default: lead_zero = 1'b0;
    endcase
  end
`else
  assign lead_zero = 1'b0;
`endif

  always_comb begin
    active = (tick_cnt >= TICK_LIT) && !lead_zero;
    an_d   = '1;
    seg_d  = '1;
    dp_d   = 1'b1;
    if (active) begin
      an_d  = ~(4'b0001 << digit);
      seg_d = decode(nibble);
      dp_d  = ~dp_en[digit];
    end
  end

  // Snapshot is taken on the last cycle of slot 3 so the next frame starts on a fresh, stable value.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      digit    <= '0;
      snap     <= '0;
      an_n     <= '1;
      seg_n    <= '1;
      dp_n     <= 1'b1;
    end else begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        digit    <= digit + 2'd1;
        if (digit == 2'd3) snap <= value;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      an_n  <= an_d;
      seg_n <= seg_d;
      dp_n  <= dp_d;
    end
  end

endmodule
